// File: rtl/mult_serial_approx.sv
// Bit-serial unsigned multiplier: operands shift in LSB first on two pins,
// the product shifts out two bits per beat. Optional approximate mode zeroes operand LSBs.
module mult_serial_approx #(
  parameter int WIDTH    = 16,
  parameter int APPROX_K = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       approx_en,
  input  logic       a_in,
  input  logic       b_in,
  output logic       p0,
  output logic       p1,
  output logic       p_valid,
  output logic       busy,
  output logic       done,
  output logic [1:0] dbg_state
);

  // Handshake: start is sampled only in IDLE (busy=0). p_valid marks each of the
  // WIDTH output beats. done is a single-cycle pulse in the first IDLE cycle after
  // the last beat, and a start in that cycle is accepted.

  typedef enum logic [1:0] {IDLE, LOAD, MUL, OUT} state_t;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] KEEP_MASK = ~WIDTH'((64'd1 << APPROX_K) - 64'd1);

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic                   mode;
  logic [WIDTH-1:0]       a_reg;
  logic [WIDTH-1:0]       b_reg;
  logic [2*WIDTH-1:0]     a_sh;
  logic [2*WIDTH-1:0]     acc;

  logic [WIDTH-1:0]       a_next;
  logic [WIDTH-1:0]       b_next;
  logic [WIDTH-1:0]       use_mask;

  always_comb begin
    a_next   = {a_in, a_reg[WIDTH-1:1]};
    b_next   = {b_in, b_reg[WIDTH-1:1]};
    use_mask = mode ? KEEP_MASK : '1;
  end

  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      mode    <= 1'b0;
      a_reg   <= '0;
      b_reg   <= '0;
      a_sh    <= '0;
      acc     <= '0;
      p0      <= 1'b0;
      p1      <= 1'b0;
      p_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            // Bit 0 enters at the MSB end and reaches position 0 after WIDTH-1 shifts.
            a_reg <= {a_in, {(WIDTH-1){1'b0}}};
            b_reg <= {b_in, {(WIDTH-1){1'b0}}};
            mode  <= approx_en;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          a_reg <= a_next;
          b_reg <= b_next;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 2)) begin
            a_sh  <= {{WIDTH{1'b0}}, a_next & use_mask};
            b_reg <= b_next & use_mask;
            acc   <= '0;
            cnt   <= '0;
            state <= MUL;
          end
        end
        MUL: begin
          if (b_reg[0]) acc <= acc + a_sh;
          a_sh  <= a_sh << 1;
          b_reg <= b_reg >> 1;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            cnt   <= '0;
            state <= OUT;
          end
        end
        OUT: begin
          // One extra count holds the last beat visible before the done cycle.
          if (cnt == CW'(WIDTH)) begin
            p0      <= 1'b0;
            p1      <= 1'b0;
            p_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            cnt     <= '0;
            state   <= IDLE;
          end else begin
            p0      <= acc[0];
            p1      <= acc[1];
            p_valid <= 1'b1;
            acc     <= acc >> 2;
            cnt     <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mult_serial_approx.md
Name: mult_serial_approx

Overview:
- Parametrised bit-serial multiplier core for the low-power approximate processor user area. Generalises the fixed 16x16 pad-serial multiplier to any operand width, and adds a per-operation approximate mode that truncates operand LSBs.
- Operands arrive serially on two pins. The product leaves two bits per cycle on two pins.
- Explicit start/busy/valid/done handshake, driven from io pads or LA.

Parameters:
- WIDTH, 16, operand width in bits (range 4..32). Product is 2*WIDTH bits.
- APPROX_K, 4, operand LSBs zeroed when approximate mode is selected (range 1..WIDTH-1).

Ports:
- clk  input  1  single clock for all state.
- rst  input  1  asynchronous, active-low reset. Low clears all state immediately.
- start  input  1  begin operation. Sampled only in IDLE; ignored otherwise.
- approx_en  input  1  approximate mode select. Captured on the start-sampling edge.
- a_in  input  1  serial operand A, LSB first.
- b_in  input  1  serial operand B, LSB first.
- p0  output  1  product bit 2i during output beat i.
- p1  output  1  product bit 2i+1 during output beat i.
- p_valid  output  1  high during each output beat.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the last output beat.

Behaviour:
- Reset (rst=0, asynchronous):
  - State forced to IDLE.
  - Operand, accumulator, counter and mode registers cleared.
  - p0=0, p1=0, p_valid=0, busy=0, done=0.
  - Reset deassertion is synchronous to clk. The first start is honoured on the first rising edge with rst=1.
- FSM states: IDLE, LOAD, MUL, OUT.
- IDLE:
  - On an edge with start=1: capture a_in/b_in as bit 0, latch approx_en, clear the counter, go to LOAD.
- LOAD:
  - Shift in bits 1..WIDTH-1, one per edge (WIDTH-1 edges).
  - Then apply the mask: if the latched approx_en=1, bits [APPROX_K-1:0] of both A and B are zeroed.
  - Go to MUL.
- MUL:
  - Shift-add, one B bit per cycle, for WIDTH cycles.
  - 2*WIDTH-bit accumulator; full-precision arithmetic, no overflow possible.
  - Result is the unsigned product (A_masked * B_masked). Go to OUT.
- OUT:
  - WIDTH beats with p_valid=1.
  - Beat i drives p0=P[2i], p1=P[2i+1]. Beats are ordered LSB pair first.
  - After beat WIDTH-1, go to IDLE.
- Latency:
  - First p_valid cycle starts exactly 2*WIDTH rising edges after the start-sampling edge.
  - done=1 for exactly one cycle, immediately after the last beat, with busy=0 in that cycle.
- Back-to-back operation:
  - A start in the done cycle is accepted. The next operation begins with no dead cycle.
  - A start while busy=1 is ignored and does not disturb the operation in progress.
  - approx_en and a_in/b_in toggling outside their sampling edges have no effect.
- Output quiescence:
  - p0/p1 are held 0 whenever p_valid=0.
  - done and p_valid are never high in the same cycle.
- Reset mid-operation: any state returns to IDLE at once. Outputs go to their reset values, the partial product is discarded, and no done pulse is produced.
- Boundary conditions:
  - A=0 or B=0 gives an all-zero product with the full WIDTH beats still emitted.
  - Max operands must not overflow the accumulator.
  - Counters wrap only through explicit reload.

Test Plan:
- Exact small (WIDTH=16, approx_en=0): A=0x0003, B=0x0005 -> P=0x0000000F. Beats 0,1 give {p1,p0}=2'b11; beats 2..15 give 00. done pulses once, 48 cycles after the start edge.
- Exact/approx compare: A=0x00FF, B=0x0013.
  - approx_en=0 -> P=0x000012ED.
  - approx_en=1 (K=4) -> masked 0x00F0*0x0010 -> P=0x00000F00.
- Max operands: A=B=0xFFFF.
  - Exact -> P=0xFFFE0001.
  - Approx -> P=0xFFE00100.
  - No overflow, 16 valid beats.
- Handshake:
  - start pulsed during MUL -> ignored, first result unchanged.
  - start in the done cycle with A=2, B=7 -> second P=0x0000000E, no idle gap.
- Reset mid-run: rst low for 1 cycle during OUT beat 5 -> p_valid/busy/p0/p1 drop to 0 asynchronously, no done. A following start with A=B=1 -> P=0x00000001.
- Parameter sweep: WIDTH=8, APPROX_K=2, 200 random operands in each mode -> matches the reference model.
  - Output has 8 beats and first p_valid 16 edges after start.
